// File: rtl/iob_2p_assim_fifo_ctrl_pkg.sv
// Shared sizing helpers for the asymmetric-width FIFO controller: narrow-unit
// width, widest address, per-port unit counts and capacity.
package iob_2p_assim_fifo_ctrl_pkg;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int min_f(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Number of narrow units carried by one word of width data_w.
  function automatic int units_f(input int data_w, input int other_w);
    return data_w / min_f(data_w, other_w);
  endfunction

  function automatic int cap_f(input int w_addr_w, input int r_addr_w);
    return 1 << max_f(w_addr_w, r_addr_w);
  endfunction

endpackage

// File: rtl/iob_2p_assim_fifo_ctrl.sv
// Single-clock FIFO controller driving both ports of iob_2p_assim_mem.
// Optional sticky overflow/underflow flags under IOB_2P_ASSIM_FIFO_ERR_EN.
module iob_2p_assim_fifo_ctrl
  import iob_2p_assim_fifo_ctrl_pkg::*;
#(
  parameter int W_DATA_W = 16,
  parameter int W_ADDR_W = 6,
  parameter int R_DATA_W = 8,
  parameter int R_ADDR_W = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               w_req,
  input  logic [W_DATA_W-1:0]                w_data,
  output logic                               w_full,
  input  logic                               r_req,
  output logic [R_DATA_W-1:0]                r_data,
  output logic                               r_valid,
  output logic                               r_empty,
  output logic [max_f(W_ADDR_W, R_ADDR_W):0] level,
  output logic                               mem_w_en,
  output logic                               mem_w_port_en,
  output logic [W_ADDR_W-1:0]                mem_w_addr,
  output logic [W_DATA_W-1:0]                mem_data_in,
  output logic                               mem_r_port_en,
  output logic [R_ADDR_W-1:0]                mem_r_addr,
  input  logic [R_DATA_W-1:0]                mem_data_out
`ifdef IOB_2P_ASSIM_FIFO_ERR_EN
  ,
  input  logic                               err_clr,
  output logic                               w_ovf,
  output logic                               r_udf
`endif
);

  localparam int MIN_W      = min_f(W_DATA_W, R_DATA_W);
  localparam int MAX_ADDR_W = max_f(W_ADDR_W, R_ADDR_W);
  localparam int WU         = units_f(W_DATA_W, R_DATA_W);
  localparam int RU         = units_f(R_DATA_W, W_DATA_W);
  localparam int CAP        = cap_f(W_ADDR_W, R_ADDR_W);
  localparam int LVL_W      = MAX_ADDR_W + 1;

  if (W_DATA_W * (1 << W_ADDR_W) != R_DATA_W * (1 << R_ADDR_W)) begin : g_bad_size
    $error("iob_2p_assim_fifo_ctrl: write and read sides must cover the same number of bits");
  end
  if ((W_DATA_W % MIN_W != 0) || (R_DATA_W % MIN_W != 0) ||
      ((1 << clog2_f(WU * RU)) != WU * RU)) begin : g_bad_ratio
    $error("iob_2p_assim_fifo_ctrl: width ratio must be a power of two");
  end

  logic [W_ADDR_W-1:0] w_ptr;
  logic [R_ADDR_W-1:0] r_ptr;
  logic                w_acc;
  logic                r_acc;

  assign w_full  = level > LVL_W'(CAP - WU);
  assign r_empty = level < LVL_W'(RU);
  assign w_acc   = w_req & ~w_full;
  assign r_acc   = r_req & ~r_empty;

  assign mem_w_en      = w_acc;
  assign mem_w_port_en = w_acc;
  assign mem_w_addr    = w_ptr;
  assign mem_data_in   = w_data;
  assign mem_r_port_en = r_acc;
  assign mem_r_addr    = r_ptr;
  assign r_data        = mem_data_out;

  // Stage boundary: pointers and level advance; r_valid tracks the memory's one-cycle read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_acc) w_ptr <= w_ptr + W_ADDR_W'(1);
      if (r_acc) r_ptr <= r_ptr + R_ADDR_W'(1);
      level   <= level + (w_acc ? LVL_W'(WU) : '0) - (r_acc ? LVL_W'(RU) : '0);
      r_valid <= r_acc;
    end
  end

`ifdef IOB_2P_ASSIM_FIFO_ERR_EN
  // A fresh violation in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (err_clr) begin
        w_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      if (w_req & w_full)  w_ovf <= 1'b1;
      if (r_req & r_empty) r_udf <= 1'b1;
    end
  end
`endif

endmodule
